fpga_top: RTL and testbench

FPGA_TOP -- requirements
Module: fpga_top

---
 rtl/fpga_top.sv | 217 +++++++++++++++++++++
 tb/tb_fpga_top.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fpga_top.sv
// Store-and-forward XGMII echo: good RX frames are buffered whole, then replayed on TX.
// Optional statistics counters and LED display are enabled by defining FPGA_TOP_STATS_EN.
module fpga_top #(
   parameter int FIFO_WORDS = 512,
   parameter int MAX_FRAMES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btnu,
   input  logic        btnl,
   input  logic        btnd,
   input  logic        btnr,
   input  logic        btnc,
   input  logic [3:0]  sw,
   output logic [7:0]  led,
   input  logic [63:0] xgmii_rxd,
   input  logic [7:0]  xgmii_rxc,
   output logic [63:0] xgmii_txd,
   output logic [7:0]  xgmii_txc
);
   localparam int AW = $clog2(FIFO_WORDS);
   localparam int QW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
   localparam logic [63:0] IDLE_D = 64'h0707070707070707;

   typedef enum logic [1:0] {IDLE, SEND, IFG} tx_state_t;

   logic [71:0]   mem [FIFO_WORDS];
   logic [71:0]   mem_q;
   logic [AW:0]   lq [MAX_FRAMES];
   logic [AW:0]   wr_ptr, base_ptr, rd_ptr, frm_len;
   logic [QW-1:0] lq_wr, lq_rd;
   logic [QW:0]   lq_cnt;
   logic          in_frame;

   logic          sof, other_sof, ctl_term, ctl_err;
   logic          rx_act, rx_full, rx_wr, rx_push, rx_drop, q_full;
   logic [AW:0]   wptr_eff, len_eff, occ;

   tx_state_t     tx_state;
   logic [AW:0]   tx_left, lq_head;
   logic          ifg_cnt, rd_en, rd_vld, lq_pop, tx_last, tx_busy;
   logic [23:0]   hb_cnt;
   logic          hb;
   logic [5:0]    led_lo;

   function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
      return (p == QW'(MAX_FRAMES - 1)) ? '0 : p + QW'(1);
   endfunction

   always_comb begin
      ctl_term  = 1'b0;
      ctl_err   = 1'b0;
      other_sof = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (xgmii_rxc[i]) begin
            if (xgmii_rxd[8*i +: 8] == 8'hFD) ctl_term = 1'b1;
            if (xgmii_rxd[8*i +: 8] == 8'hFE) ctl_err = 1'b1;
            if (i > 0 && xgmii_rxd[8*i +: 8] == 8'hFB) other_sof = 1'b1;
         end
      end
   end

   // A lane-0 start always (re)opens a frame at the committed base pointer,
   // which also rolls back any frame it interrupts.
   assign sof      = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB);
   assign rx_act   = sof || in_frame;
   assign wptr_eff = sof ? base_ptr : wr_ptr;
   assign len_eff  = sof ? (AW+1)'(1) : frm_len + (AW+1)'(1);
   assign occ      = wptr_eff - rd_ptr;
   assign rx_full  = (occ == (AW+1)'(FIFO_WORDS));
   assign q_full   = (lq_cnt == (QW+1)'(MAX_FRAMES));
   assign rx_wr    = rx_act && !rx_full && !ctl_err;
   assign rx_push  = rx_wr && ctl_term && !q_full;
   assign rx_drop  = (rx_act && !rx_wr) || (rx_wr && ctl_term && q_full) || (in_frame && sof);

   assign lq_head  = lq[lq_rd];
   assign lq_pop   = (tx_state == IDLE) && (lq_cnt != '0);
   assign rd_en    = lq_pop || (tx_state == SEND);
   assign tx_last  = (lq_pop && lq_head == (AW+1)'(1)) ||
                     (tx_state == SEND && tx_left == (AW+1)'(1));

   always_ff @(posedge clk) begin
      if (rx_wr)   mem[wptr_eff[AW-1:0]] <= {xgmii_rxc, xgmii_rxd};
      if (rd_en)   mem_q <= mem[rd_ptr[AW-1:0]];
      if (rx_push) lq[lq_wr] <= len_eff;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_frame <= 1'b0;
         wr_ptr   <= '0;
         base_ptr <= '0;
         frm_len  <= '0;
         lq_wr    <= '0;
         lq_rd    <= '0;
         lq_cnt   <= '0;
      end else begin
         if (rx_act) begin
            if (!rx_wr || (ctl_term && q_full)) begin
               in_frame <= 1'b0;
               wr_ptr   <= base_ptr;
            end else if (ctl_term) begin
               in_frame <= 1'b0;
               wr_ptr   <= wptr_eff + (AW+1)'(1);
               base_ptr <= wptr_eff + (AW+1)'(1);
            end else begin
               in_frame <= 1'b1;
               wr_ptr   <= wptr_eff + (AW+1)'(1);
               frm_len  <= len_eff;
            end
         end
         if (rx_push) lq_wr <= q_next(lq_wr);
         if (lq_pop)  lq_rd <= q_next(lq_rd);
         lq_cnt <= lq_cnt + (QW+1)'(rx_push) - (QW+1)'(lq_pop);
      end
   end

   // The FSM tracks read issue; the wire lags it by two cycles (RAM read + output reg).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state  <= IDLE;
         tx_left   <= '0;
         ifg_cnt   <= 1'b0;
         rd_ptr    <= '0;
         rd_vld    <= 1'b0;
         tx_busy   <= 1'b0;
         xgmii_txd <= IDLE_D;
         xgmii_txc <= 8'hFF;
      end else begin
         case (tx_state)
            IDLE: if (lq_pop) begin
               tx_left <= lq_head - (AW+1)'(1);
               ifg_cnt <= 1'b0;
               tx_state <= tx_last ? IFG : SEND;
            end
            SEND: begin
               tx_left <= tx_left - (AW+1)'(1);
               ifg_cnt <= 1'b0;
               if (tx_last) tx_state <= IFG;
            end
            IFG: begin
               ifg_cnt <= 1'b1;
               if (ifg_cnt) tx_state <= IDLE;
            end
            default: tx_state <= IDLE;
         endcase
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
         rd_vld    <= rd_en;
         tx_busy   <= rd_vld;
         xgmii_txd <= rd_vld ? mem_q[63:0]  : IDLE_D;
         xgmii_txc <= rd_vld ? mem_q[71:64] : 8'hFF;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hb_cnt <= '0;
         hb     <= 1'b0;
      end else begin
         hb_cnt <= hb_cnt + 24'd1;
         if (&hb_cnt) hb <= ~hb;
      end
   end

`ifdef FPGA_TOP_STATS_EN
   logic [1:0]  btnc_sync;
   logic [15:0] cnt_good, cnt_done, cnt_drop, occ16;
   logic [5:0]  led_sel;
   logic        unused_bits;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
   endfunction

   assign occ16 = 16'(wr_ptr - rd_ptr);

   always_comb begin
      case (sw[1:0])
         2'd0:    led_sel = cnt_good[5:0];
         2'd1:    led_sel = cnt_done[5:0];
         2'd2:    led_sel = cnt_drop[5:0];
         default: led_sel = occ16[8:3];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btnc_sync <= '0;
         cnt_good  <= '0;
         cnt_done  <= '0;
         cnt_drop  <= '0;
         led_lo    <= '0;
      end else begin
         btnc_sync <= {btnc_sync[0], btnc};
         if (btnc_sync[1]) begin
            cnt_good <= '0;
            cnt_done <= '0;
            cnt_drop <= '0;
         end else begin
            cnt_good <= sat_inc(cnt_good, rx_push);
            cnt_done <= sat_inc(cnt_done, tx_last);
            cnt_drop <= sat_inc(cnt_drop, rx_drop || other_sof);
         end
         led_lo <= led_sel;
      end
   end

   assign unused_bits = ^{btnu, btnl, btnd, btnr, sw[3:2], occ16};
`else
   logic unused_bits;
   assign led_lo      = '0;
   assign unused_bits = ^{btnu, btnl, btnd, btnr, btnc, sw, rx_drop, other_sof, tx_last};
`endif

   assign led = {hb, tx_busy, led_lo};

endmodule

// File: tb/tb_fpga_top.sv
// Scoreboard bench for the XGMII echo: RX frames queue expected TX words, a monitor
// compares every TX word, plus latency, inter-frame gap and LED/counter checks.
module tb_fpga_top;
   localparam logic [63:0] IDLE_D = 64'h0707070707070707;
   localparam logic [71:0] IDLE_W = {8'hFF, IDLE_D};
`ifdef FPGA_TOP_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0, rst = 1'b1;
   logic        btnu = 1'b0, btnl = 1'b0, btnd = 1'b0, btnr = 1'b0, btnc = 1'b0;
   logic [3:0]  sw = 4'd0;
   logic [7:0]  led;
   logic [63:0] rxd = IDLE_D, txd;
   logic [7:0]  rxc = 8'hFF, txc;

   int checks = 0, fails = 0, cyc = 0;
   logic [71:0] sb[$];
   bit mon_in = 0, mon_en = 0, gap_en = 0;
   int last_term = 0, last_start = 0, n_tx = 0, n_start = 0, t_drv = 0;

   fpga_top dut (
      .clk(clk), .rst(rst), .btnu(btnu), .btnl(btnl), .btnd(btnd), .btnr(btnr),
      .btnc(btnc), .sw(sw), .led(led), .xgmii_rxd(rxd), .xgmii_rxc(rxc),
      .xgmii_txd(txd), .xgmii_txc(txc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_term(input logic [71:0] w);
      for (int i = 0; i < 8; i++)
         if (w[64+i] && w[8*i +: 8] == 8'hFD) return 1'b1;
      return 1'b0;
   endfunction

   always @(negedge clk) begin : mon
      logic [71:0] w;
      bit fw;
      if (mon_en) begin
         w  = {txc, txd};
         fw = mon_in || (w[64] && w[7:0] == 8'hFB);
         chk("led6", 72'(led[6]), 72'(fw));
         if (fw) begin
            if (!mon_in) begin
               mon_in = 1;
               last_start = cyc;
               n_start++;
               if (gap_en) chk("gap", 72'(cyc - last_term), 72'(3));
            end
            if (sb.size() == 0) chk("extra", w, IDLE_W);
            else chk("txd", w, sb.pop_front());
            if (is_term(w)) begin
               mon_in = 0;
               last_term = cyc;
               n_tx++;
            end
         end else begin
            chk("idle", w, IDLE_W);
         end
      end
   end

   task automatic drive(input logic [63:0] d, input logic [7:0] c);
      @(negedge clk);
      rxd = d;
      rxc = c;
   endtask

   task automatic send_frame(input int nw, input int err_w, input bit term, input bit good);
      logic [63:0] d;
      logic [7:0]  c;
      for (int i = 0; i < nw; i++) begin
         if (i == 0) begin
            d = 64'hD5555555555555FB; c = 8'h01;
         end else if (term && i == nw - 1) begin
            d = {24'h070707, 8'hFD, 32'($urandom())}; c = 8'hF0;
         end else begin
            d = {32'($urandom()), 32'($urandom())}; c = 8'h00;
         end
         if (i == err_w) begin
            d[31:24] = 8'hFE; c[3] = 1'b1;
         end
         drive(d, c);
         if (term && i == nw - 1) t_drv = cyc;
         if (good) sb.push_back({c, d});
      end
      drive(IDLE_D, 8'hFF);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !mon_in) break;
      end
      chk("drain", 72'(sb.size()), 72'(0));
      repeat (4) @(negedge clk);
   endtask

   task automatic led_chk(input logic [3:0] s, input int v);
      sw = s;
      repeat (2) @(negedge clk);
      chk($sformatf("led sw=%0d", s), 72'(led[5:0]), STATS ? 72'(v & 63) : 72'(0));
   endtask

   task automatic led_all(input int g, input int d, input int p);
      led_chk(4'd0, g);
      led_chk(4'd1, d);
      led_chk(4'd2, p);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, s0;
      #2 rst = 1'b0;
      mon_en = 1;
      repeat (3) @(negedge clk);
      chk("rst led", 72'(led), 72'(0));
      chk("rst tx", {txc, txd}, IDLE_W);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      led_all(0, 0, 0);

      // single frame, start latency
      send_frame(10, -1, 1, 1);
      t1 = t_drv;
      wait_drain();
      chk("latency", 72'(last_start - t1), 72'(3));
      chk("ntx1", 72'(n_tx), 72'(1));
      led_all(1, 1, 0);

      // error in lane 3 of word 5
      send_frame(10, 4, 1, 0);
      wait_drain();
      chk("ntx err", 72'(n_tx), 72'(1));
      led_chk(4'd2, 1);

      // start in lane 4 is ignored but counted
      drive(64'h070707FB07070707, 8'hFF);
      drive(IDLE_D, 8'hFF);
      wait_drain();
      led_chk(4'd2, 2);

      // three back-to-back frames
      s0 = n_start;
      fork
         begin
            for (int f = 0; f < 3; f++) send_frame(10, -1, 1, 1);
         end
         begin
            for (int i = 0; i < 200; i++) begin
               @(negedge clk);
               if (n_start > s0) break;
            end
            gap_en = 1;
         end
      join
      wait_drain();
      gap_en = 0;
      chk("ntx b2b", 72'(n_tx), 72'(4));
      led_all(4, 4, 2);

      // oversize frame, then a good one
      send_frame(2000, -1, 1, 0);
      send_frame(10, -1, 1, 1);
      wait_drain();
      chk("ntx big", 72'(n_tx), 72'(5));
      led_all(5, 5, 3);

      // new start before terminate discards the open frame
      send_frame(4, -1, 0, 0);
      send_frame(10, -1, 1, 1);
      wait_drain();
      chk("ntx pre", 72'(n_tx), 72'(6));
      led_all(6, 6, 4);
      led_chk(4'd3, 0);

      // reset mid-frame
      send_frame(5, -1, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      led_all(0, 0, 0);
      send_frame(10, -1, 1, 1);
      wait_drain();
      chk("ntx rst", 72'(n_tx), 72'(7));
      led_all(1, 1, 0);

      // counter clear
      @(negedge clk);
      btnc = 1'b1;
      repeat (3) @(negedge clk);
      btnc = 1'b0;
      repeat (4) @(negedge clk);
      led_all(0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
